minority_vote_pipe: RTL and testbench

//   Parametrised, pipelined N-input bitwise voter. It is the sequential successor to the 3-input combinational minority gate.

---
 rtl/minority_vote_pipe.sv | 101 ++++++++++
 tb/tb_minority_vote_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minority_vote_pipe.sv
// Two-stage pipelined N-input bitwise minority/majority voter with a valid/ready stream.
// Optional MINORITY_VOTE_STATS_EN builds the saturating disagreement counter; otherwise disagree_cnt is tied to 0.
module minority_vote_pipe #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic                    in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_unanim,
    output logic [CNT_W-1:0]        disagree_cnt
);

    localparam int unsigned OW   = $clog2(N_IN + 1);
    localparam int unsigned HALF = (N_IN - 1) / 2;

    logic [WIDTH-1:0][N_IN-1:0] col_c;
    logic [WIDTH-1:0][OW-1:0]   ones_c;
    logic [WIDTH-1:0]           lane_un_c;
    logic                       unanim_c;
    logic                       s2_load_c;

    logic                       s1_valid;
    logic [WIDTH-1:0][OW-1:0]   s1_ones;
    logic                       s1_mode;
    logic                       s1_unanim;
    logic [WIDTH-1:0]           maj_c;
    logic [WIDTH-1:0]           res_c;

    // Regroup the input into one column of N_IN votes per bit position.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        for (genvar k = 0; k < N_IN; k++) begin : g_word
            assign col_c[b][k] = in_data[k*WIDTH + b];
        end
        assign ones_c[b]    = OW'($countones(col_c[b]));
        assign lane_un_c[b] = (col_c[b] == '0) || (col_c[b] == '1);
        assign maj_c[b]     = (s1_ones[b] > OW'(HALF));
    end

    assign unanim_c  = &lane_un_c;
    assign res_c     = s1_mode ? maj_c : ~maj_c;
    assign s2_load_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load_c;

    // Stage 1: per-bit popcount, mode and unanimity flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_ones   <= '0;
            s1_mode   <= 1'b0;
            s1_unanim <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ones   <= ones_c;
                s1_mode   <= in_mode;
                s1_unanim <= unanim_c;
            end
        end
    end

    // Stage 2: voted result held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_unanim <= 1'b0;
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= res_c;
                out_unanim <= s1_unanim;
            end
        end
    end

`ifdef MINORITY_VOTE_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts accepted non-unanimous beats, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (in_valid && in_ready && !unanim_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign disagree_cnt = cnt_q;
`else
    assign disagree_cnt = '0;
`endif

endmodule

// File: tb/tb_minority_vote_pipe.sv
// Scoreboard bench for minority_vote_pipe: 3x8-bit instance under random backpressure plus a 5x1-bit sweep instance.
// Expected disagree_cnt follows MINORITY_VOTE_STATS_EN.
module tb_minority_vote_pipe;

    localparam int N      = 3;
    localparam int W      = 8;
    localparam int CW     = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  in_data;
    logic            in_mode;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_unanim;
    logic [CW-1:0]   disagree_cnt;

    logic            rst5_n;
    logic            v5_valid;
    logic            in_ready5;
    logic [4:0]      v5_data;
    logic            v5_mode;
    logic            out5_valid;
    logic [0:0]      out5_data;
    logic            out5_unanim;
    logic [CW-1:0]   cnt5;

    always #5 clk = ~clk;

    minority_vote_pipe #(.N_IN(N), .WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_unanim(out_unanim), .disagree_cnt(disagree_cnt)
    );

    minority_vote_pipe #(.N_IN(5), .WIDTH(1), .CNT_W(CW)) u_dut5 (
        .clk(clk), .rst_n(rst5_n), .in_valid(v5_valid), .in_ready(in_ready5),
        .in_data(v5_data), .in_mode(v5_mode), .out_valid(out5_valid), .out_ready(1'b1),
        .out_data(out5_data), .out_unanim(out5_unanim), .disagree_cnt(cnt5)
    );

    typedef struct {
        logic [15:0] data;
        logic        un;
    } exp_t;

    exp_t q[$];
    exp_t q5[$];
    int   errs = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    int   or_mode = 1;
    bit   mon_en = 0;
    bit   done5 = 0;
    bit   held = 0;
    logic [7:0] held_d;
    logic       held_u;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int bit_of(input logic [63:0] d, input int i);
        return int'((d >> i) & 64'd1);
    endfunction

    // Reference vote: count ones per column; majority means more than half of the n voters.
    function automatic void vote_ref(input logic [63:0] d, input int n, input int w, input logic mode,
                                     output logic [15:0] res, output logic un);
        res = '0;
        un  = 1'b1;
        for (int b = 0; b < w; b++) begin
            int ones = 0;
            for (int k = 0; k < n; k++) begin
                ones += bit_of(d, k*w + b);
                if (bit_of(d, k*w + b) != bit_of(d, b)) un = 1'b0;
            end
            if ((2*ones > n) == (mode == 1'b1)) res = res | (16'd1 << b);
        end
    endfunction

    function automatic logic [N*W-1:0] rand_beat();
        logic [7:0] w0 = 8'($urandom);
        if ($urandom_range(0, 3) == 0) return {w0, w0, w0};
        return 24'($urandom);
    endfunction

    always @(negedge clk) begin
        case (or_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic drive(input logic [N*W-1:0] d, input logic m, input bit use_exp,
                         input logic [7:0] xd, input logic xu);
        bit acc = 0;
        int tries = 0;
        logic [15:0] r;
        logic u;
        exp_t e;
        while (!acc) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_mode  = m;
            #1;
            acc = in_ready;
            @(posedge clk);
            tries++;
            if (!acc && tries > 200) begin
                check("accept_timeout", 32'(acc), 32'd1);
                break;
            end
        end
        if (acc) begin
            vote_ref(64'(d), N, W, m, r, u);
            e.data = use_exp ? 16'(xd) : r;
            e.un   = use_exp ? xu : u;
            q.push_back(e);
`ifdef MINORITY_VOTE_STATS_EN
            if (!u && exp_cnt < CNT_MAX) exp_cnt++;
`endif
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        or_mode = 1;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: pops the scoreboard on every consumed result and checks hold stability under stall.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mon_en && rst_n) begin
            check("disagree_cnt", 32'(disagree_cnt), 32'(exp_cnt));
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", {23'd0, out_unanim, out_data}, {23'd0, held_u, held_d});
            end
            if (out_valid && out_ready) begin
                held = 0;
                if (q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data[7:0]));
                    check("out_unanim", 32'(out_unanim), 32'(e.un));
                end
            end else if (out_valid) begin
                held   = 1;
                held_d = out_data;
                held_u = out_unanim;
            end else begin
                held = 0;
            end
        end else begin
            held = 0;
        end
    end

    // 5-input, 1-bit instance: exhaustive sweep in both modes.
    initial begin
        logic [15:0] r;
        logic u;
        exp_t e;
        rst5_n = 1'b0; v5_valid = 1'b0; v5_data = '0; v5_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst5_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                v5_valid = 1'b1;
                v5_data  = 5'(c);
                v5_mode  = 1'(m);
                #1;
                check("dut5_ready", 32'(in_ready5), 32'd1);
                @(posedge clk);
                vote_ref(64'(c), 5, 1, 1'(m), r, u);
                e.data = r;
                e.un   = u;
                q5.push_back(e);
            end
        end
        @(negedge clk);
        v5_valid = 1'b0;
        done5 = 1;
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst5_n && out5_valid) begin
            if (q5.size() == 0) begin
                check("dut5_unexpected", 32'(out5_valid), 32'd0);
            end else begin
                e = q5.pop_front();
                check("dut5_data", 32'(out5_data), 32'(e.data[0]));
                check("dut5_unanim", 32'(out5_unanim), 32'(e.un));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_unanim", 32'(out_unanim), 32'd0);
        check("rst_cnt", 32'(disagree_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1;

        // All-zero beat in minority mode, with exact two-cycle latency.
        or_mode = 1;
        drive(24'h000000, 1'b0, 1, 8'hFF, 1'b1);
        @(negedge clk); #3;
        check("latency_c1", 32'(out_valid), 32'd0);
        @(negedge clk); #3;
        check("latency_c2", 32'(out_valid), 32'd1);

        // Every 3-input combination sits in one bit lane of this pattern.
        drive(24'hF0CCAA, 1'b1, 1, 8'hE8, 1'b0);
        drive(24'hF0CCAA, 1'b0, 1, 8'h17, 1'b0);
        drain();

        // Stall capacity: two beats held, the third refused until the consumer resumes.
        or_mode = 2;
        drive(24'h123456, 1'b1, 0, 8'h00, 1'b0);
        drive(24'h654321, 1'b0, 0, 8'h00, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 24'hA5A5A5; in_mode = 1'b0;
        #1;
        check("stall_refuse", 32'(in_ready), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        or_mode = 1;
        drive(24'hA5A5A5, 1'b0, 0, 8'h00, 1'b0);
        drain();

        // Reset while a result is waiting.
        or_mode = 2;
        drive(24'h0F00FF, 1'b1, 0, 8'h00, 1'b0);
        drive(24'h3C5A7E, 1'b0, 0, 8'h00, 1'b0);
        @(negedge clk); #3;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        check("reset_async_valid", 32'(out_valid), 32'd0);
        check("reset_async_cnt", 32'(disagree_cnt), 32'd0);
        q.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        or_mode = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            check("no_stale_output", 32'(out_valid), 32'd0);
        end
        mon_en = 1;

        // Saturation: 9 disagreeing beats plus 2 unanimous ones.
        for (int i = 0; i < 9; i++) begin
            logic [7:0] w0 = 8'($urandom);
            logic [7:0] w1 = w0 ^ 8'($urandom_range(1, 255));
            drive({8'($urandom), w1, w0}, 1'($urandom), 0, 8'h00, 1'b0);
        end
        drive(24'h5A5A5A, 1'b1, 0, 8'h00, 1'b0);
        drive(24'hFFFFFF, 1'b0, 0, 8'h00, 1'b0);
        drain();
`ifdef MINORITY_VOTE_STATS_EN
        check("sat_cnt", 32'(disagree_cnt), 32'd7);
`else
        check("sat_cnt", 32'(disagree_cnt), 32'd0);
`endif

        // Random traffic with idle gaps and random backpressure.
        or_mode = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 24'($urandom);
                in_mode  = 1'($urandom);
                @(posedge clk);
            end else begin
                drive(rand_beat(), 1'($urandom), 0, 8'h00, 1'b0);
            end
        end
        drain();

        for (int i = 0; i < 500; i++) begin
            if (done5 && q5.size() == 0) break;
            @(posedge clk);
        end
        check("dut5_complete", 32'(done5 && (q5.size() == 0)), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
